// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers. It uses a MUL_LAT-stage
// pipelined multiplier and an iterative radix-2 restoring divider.
module mdu_hilo #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             flush_e_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned DW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDfix} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [DW-1:0]     pipe_q [MUL_LAT];

    logic              accept, is_mult, is_div, mul_en, sub_ok;
    logic              a_sign, b_sign;
    logic [DW-1:0]     a_ext, b_ext, product;
    logic [WIDTH-1:0]  a_mag, b_mag, quo_fix, rem_fix;
    logic [DW-1:0]     rem_sh, rem_sub, dvs_ext;

    assign accept  = start_i & ~flush_e_i & (state_q == StIdle);
    assign is_mult = (op_i == OpMult) | (op_i == OpMultu);
    assign is_div  = (op_i == OpDiv);
    assign a_sign  = srca_i[WIDTH-1];
    assign b_sign  = srcb_i[WIDTH-1];

    // Low 2*WIDTH bits of an unsigned product of extended operands are correct for both signs
    assign a_ext   = (op_i == OpMult) ? {{WIDTH{a_sign}}, srca_i} : {{WIDTH{1'b0}}, srca_i};
    assign b_ext   = (op_i == OpMult) ? {{WIDTH{b_sign}}, srcb_i} : {{WIDTH{1'b0}}, srcb_i};
    assign product = a_ext * b_ext;
    assign mul_en  = (accept & is_mult) | (state_q == StMul);

    assign a_mag   = (is_div && a_sign) ? -srca_i : srca_i;
    assign b_mag   = (is_div && b_sign) ? -srcb_i : srcb_i;

    // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB
    assign rem_sh  = {rem_q[DW-2:0], quo_q[WIDTH-1]};
    assign dvs_ext = {{WIDTH{1'b0}}, dvs_q};
    assign rem_sub = rem_sh - dvs_ext;
    assign sub_ok  = (rem_sh >= dvs_ext);
    assign quo_fix = q_neg_q ? -quo_q : quo_q;
    assign rem_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op_i)
                        OpMult, OpMultu: begin
                            state_d = StMul;
                            cnt_d   = CntW'(MUL_LAT - 1);
                        end
                        OpDiv, OpDivu: begin
                            if (srcb_i == '0) begin
                                state_d = StDfix;
                                quo_d   = '1;
                                rem_d   = {{WIDTH{1'b0}}, srca_i};
                                q_neg_d = 1'b0;
                                r_neg_d = 1'b0;
                            end else begin
                                state_d = StDiv;
                                cnt_d   = CntW'(WIDTH - 1);
                                quo_d   = a_mag;
                                dvs_d   = b_mag;
                                rem_d   = '0;
                                q_neg_d = is_div & (a_sign ^ b_sign);
                                r_neg_d = is_div & a_sign;
                            end
                        end
                        OpMthi:  hi_d = srca_i;
                        OpMtlo:  lo_d = srca_i;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = pipe_q[MUL_LAT-1];
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDiv: begin
                rem_d = sub_ok ? rem_sub : rem_sh;
                quo_d = {quo_q[WIDTH-2:0], sub_ok};
                if (cnt_q == '0) begin
                    state_d = StDfix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDfix: begin
                lo_d    = quo_fix;
                hi_d    = rem_fix;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mul_en) begin
            pipe_q[0] <= product;
            for (int k = 1; k < MUL_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo (WIDTH=32, MUL_LAT=3).
module tb_mdu_hilo;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_hilo #(
        .WIDTH   (32),
        .MUL_LAT (3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .op_i      (op),
        .flush_e_i (flush),
        .srca_i    (srca),
        .srcb_i    (srcb),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accept edge until done; commit edge N+lat shows done at lat+1
    task automatic wait_done(input string tag, input int lat,
                             input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] h0, l0;
        logic        held, got_done;
        int          k, bcnt;
        h0 = hi;
        l0 = lo;
        held = 1'b1;
        got_done = 1'b0;
        k = 0;
        bcnt = 0;
        while (k < 200 && !got_done) begin
            @(negedge clk);
            k++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (hi !== h0 || lo !== l0) held = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, 64'(k), 64'(lat + 1));
        check_eq({tag, "_busy_cycles"}, 64'(bcnt), 64'(lat));
        check_eq({tag, "_hold"}, 64'(held), 64'd1);
        check_eq({tag, "_hi"}, 64'(hi), 64'(ehi));
        check_eq({tag, "_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] ehi, input logic [31:0] elo);
        launch(o, a, 32'd0);
        @(negedge clk);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_hi"}, 64'(hi), 64'(ehi));
        check_eq({tag, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        logic busy_seen;
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        srca  = '0;
        srcb  = '0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        launch(OpMult, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("mult_neg", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        launch(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 3, 32'hFFFF_FFFE, 32'h0000_0001);

        launch(OpDiv, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg_dividend", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        launch(OpDiv, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_neg_divisor", 33, 32'd1, 32'hFFFF_FFFD);

        // A second start (MTLO) while the divide is running must be ignored
        launch(OpDivu, 32'd100, 32'd7);
        @(negedge clk);
        check_eq("divu_busy_at_restart", 64'(busy), 64'd1);
        start = 1'b1;
        op    = OpMtlo;
        srca  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("divu_ignore_start", 32, 32'd2, 32'd14);

        launch(OpDivu, 32'd5, 32'd0);
        wait_done("divu_by_zero", 1, 32'd5, 32'hFFFF_FFFF);

        launch(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_overflow", 33, 32'd0, 32'h8000_0000);

        mt_op("mthi", OpMthi, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000);
        mt_op("mtlo", OpMtlo, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OpMultu;
        srca  = 32'hFFFF_FFFF;
        srcb  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) busy_seen = 1'b1;
        end
        check_eq("flush_no_launch", 64'(busy_seen), 64'd0);
        check_eq("flush_hi", 64'(hi), 64'h1234);
        check_eq("flush_lo", 64'(lo), 64'h5678);

        launch(OpDiv, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(negedge clk);
        check_eq("pre_reset_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("midop_rst_busy", 64'(busy), 64'd0);
        check_eq("midop_rst_hi", 64'(hi), 64'd0);
        check_eq("midop_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        launch(OpMult, 32'd6, 32'd7);
        wait_done("mult_after_reset", 3, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
